// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD controller and its datapath.
package gcd_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        CALC = 3'd2,
        GLD  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } gcd_state_e;

    localparam int GCD_W        = 4;
    localparam int GCD_MAX_ITER = 15;

    localparam logic SEL_IN   = 1'b0;
    localparam logic SEL_DIFF = 1'b1;

endpackage

// File: rtl/gcd_ctrl.sv
// Control FSM for the subtractive-Euclid GCD datapath, with go/done/ack
// handshake, zero-operand rejection, iteration counting and timeout.
module gcd_ctrl
    import gcd_pkg::*;
#(
    parameter int W        = GCD_W,
    parameter int MAX_ITER = GCD_MAX_ITER,
    localparam int CW      = $clog2(MAX_ITER + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          go,
    input  logic          ack,
    input  logic [W-1:0]  xin,
    input  logic [W-1:0]  yin,
    input  logic          eqflg,
    input  logic          ltflg,
    output logic          xmsel,
    output logic          ymsel,
    output logic          xld,
    output logic          yld,
    output logic          gld,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] iters
);

    localparam logic [CW-1:0] ITER_LIMIT = CW'(MAX_ITER);

    gcd_state_e    state_q, state_d;
    logic [CW-1:0] iters_q, iters_d;
    logic          at_limit;

    assign at_limit = (iters_q == ITER_LIMIT);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            iters_q <= '0;
        end else begin
            state_q <= state_d;
            iters_q <= iters_d;
        end
    end

    always_comb begin
        state_d = state_q;
        iters_d = iters_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    if ((xin == '0) || (yin == '0)) begin
                        state_d = ERR;
                    end else begin
                        state_d = LOAD;
                        iters_d = '0;
                    end
                end
            end
            LOAD: state_d = CALC;
            CALC: begin
                // Equality beats the timeout so a run finishing on its last allowed step still succeeds.
                if (eqflg) begin
                    state_d = GLD;
                end else if (at_limit) begin
                    state_d = ERR;
                end else begin
                    iters_d = iters_q + 1'b1;
                end
            end
            GLD:  state_d = DONE;
            DONE: if (ack) state_d = IDLE;
            ERR:  if (ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        xmsel = SEL_IN;
        ymsel = SEL_IN;
        xld   = 1'b0;
        yld   = 1'b0;
        gld   = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        err   = 1'b0;
        case (state_q)
            LOAD: begin
                xld  = 1'b1;
                yld  = 1'b1;
                busy = 1'b1;
            end
            CALC: begin
                busy = 1'b1;
                if (!eqflg && !at_limit) begin
                    if (ltflg) begin
                        ymsel = SEL_DIFF;
                        yld   = 1'b1;
                    end else begin
                        xmsel = SEL_DIFF;
                        xld   = 1'b1;
                    end
                end
            end
            GLD:  gld  = 1'b1;
            DONE: done = 1'b1;
            ERR:  err  = 1'b1;
            default: ;
        endcase
    end

    assign iters = iters_q;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Bench for gcd_ctrl: two controllers (default and MAX_ITER=3) each paired
// with a behavioural datapath, checked against a queued reference model.
module tb_gcd_ctrl;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       go  = 1'b0;
    logic       ack = 1'b0;
    logic [3:0] xin = '0;
    logic [3:0] yin = '0;

    logic       xmsel_a, ymsel_a, xld_a, yld_a, gld_a, busy_a, done_a, err_a;
    logic [3:0] iters_a;
    logic       xmsel_b, ymsel_b, xld_b, yld_b, gld_b, busy_b, done_b, err_b;
    logic [1:0] iters_b;
    logic [3:0] x_a, y_a, g_a, x_b, y_b, g_b;
    logic       eq_a, lt_a, eq_b, lt_b;

    always #5 clk = ~clk;

    assign eq_a = (x_a == y_a);
    assign lt_a = (x_a <  y_a);
    assign eq_b = (x_b == y_b);
    assign lt_b = (x_b <  y_b);

    gcd_ctrl #(.W(4), .MAX_ITER(15)) dut_a (
        .clk(clk), .clr(clr), .go(go), .ack(ack), .xin(xin), .yin(yin),
        .eqflg(eq_a), .ltflg(lt_a), .xmsel(xmsel_a), .ymsel(ymsel_a),
        .xld(xld_a), .yld(yld_a), .gld(gld_a), .busy(busy_a),
        .done(done_a), .err(err_a), .iters(iters_a)
    );

    gcd_ctrl #(.W(4), .MAX_ITER(3)) dut_b (
        .clk(clk), .clr(clr), .go(go), .ack(ack), .xin(xin), .yin(yin),
        .eqflg(eq_b), .ltflg(lt_b), .xmsel(xmsel_b), .ymsel(ymsel_b),
        .xld(xld_b), .yld(yld_b), .gld(gld_b), .busy(busy_b),
        .done(done_b), .err(err_b), .iters(iters_b)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            x_a <= '0; y_a <= '0; g_a <= '0;
            x_b <= '0; y_b <= '0; g_b <= '0;
        end else begin
            if (xld_a) x_a <= xmsel_a ? (x_a - y_a) : xin;
            if (yld_a) y_a <= ymsel_a ? (y_a - x_a) : yin;
            if (gld_a) g_a <= x_a;
            if (xld_b) x_b <= xmsel_b ? (x_b - y_b) : xin;
            if (yld_b) y_b <= ymsel_b ? (y_b - x_b) : yin;
            if (gld_b) g_b <= x_b;
        end
    end

    typedef struct {
        int gcd;
        int iters;
        bit err;
        int lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   gld_cnt_a = 0;
    int   gld_cnt_b = 0;
    int   last_iters_a = 0;
    int   last_iters_b = 0;
    bit   sel_b = 1'b0;
    bit   pair_seen = 1'b0;

    wire       o_busy  = sel_b ? busy_b : busy_a;
    wire       o_done  = sel_b ? done_b : done_a;
    wire       o_err   = sel_b ? err_b  : err_a;
    wire [3:0] o_gcd   = sel_b ? g_b    : g_a;
    wire [3:0] o_iters = sel_b ? {2'b00, iters_b} : iters_a;

    always @(posedge clk) begin
        if (gld_a) gld_cnt_a++;
        if (gld_b) gld_cnt_b++;
        if (xld_a && yld_a && !(xmsel_a == 1'b0 && ymsel_a == 1'b0)) pair_seen = 1'b1;
    end

    function automatic exp_t model(input int xa, input int ya, input int maxit, input int prev);
        exp_t e;
        int a, b, s;
        e.gcd = 0; e.err = 1'b0;
        if (xa == 0 || ya == 0) begin
            e.err = 1'b1; e.iters = prev; e.lat = 1;
            return e;
        end
        a = xa; b = ya; s = 0;
        while (a != b) begin
            if (s == maxit) begin
                e.err = 1'b1; e.iters = s; e.lat = maxit + 3;
                return e;
            end
            if (a < b) b = b - a; else a = a - b;
            s++;
        end
        e.gcd = a; e.iters = s; e.lat = s + 4;
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b0; go = 1'b0; ack = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        last_iters_a = 0; last_iters_b = 0;
        @(negedge clk);
    endtask

    task automatic run_op(input int xa, input int ya, input bit use_b,
                          input bit go_mid, input bit go_ack, input string name);
        exp_t e, got;
        int   lat;
        sel_b = use_b;
        e = model(xa, ya, use_b ? 3 : 15, use_b ? last_iters_b : last_iters_a);
        sb_q.push_back(e);
        xin = 4'(xa); yin = 4'(ya); go = 1'b1;
        gld_cnt_a = 0; gld_cnt_b = 0;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        go = 1'b0;
        while (!(o_done || o_err) && lat < 100) begin
            go = (go_mid && lat == 3);
            @(posedge clk);
            lat++;
            @(negedge clk);
            go = 1'b0;
        end
        got = sb_q.pop_front();
        n_checks++;
        if (!(o_done || o_err)) begin
            n_fail++;
            $display("FAIL %s_timeout: no done/err after %0d cycles, required within %0d", name, lat, got.lat);
            return;
        end
        n_checks++;
        if (lat !== got.lat) begin
            n_fail++; $display("FAIL %s_latency: got %0d required %0d", name, lat, got.lat);
        end
        n_checks++;
        if (o_err !== got.err || o_done !== !got.err) begin
            n_fail++; $display("FAIL %s_status: err=%0b done=%0b required err=%0b", name, o_err, o_done, got.err);
        end
        n_checks++;
        if (int'(o_iters) !== got.iters) begin
            n_fail++; $display("FAIL %s_iters: got %0d required %0d", name, o_iters, got.iters);
        end
        n_checks++;
        if ((use_b ? gld_cnt_b : gld_cnt_a) !== (got.err ? 0 : 1)) begin
            n_fail++; $display("FAIL %s_gld_count: got %0d required %0d", name, use_b ? gld_cnt_b : gld_cnt_a, got.err ? 0 : 1);
        end
        if (!got.err) begin
            n_checks++;
            if (int'(o_gcd) !== got.gcd) begin
                n_fail++; $display("FAIL %s_gcd: got %0d required %0d", name, o_gcd, got.gcd);
            end
        end
        if (use_b) last_iters_b = got.iters; else last_iters_a = got.iters;
        repeat (2) @(negedge clk);
        n_checks++;
        if ((o_done || o_err) !== 1'b1) begin
            n_fail++; $display("FAIL %s_hold: done|err=%0b required 1", name, o_done || o_err);
        end
        go = go_ack; ack = 1'b1;
        @(negedge clk);
        go = 1'b0; ack = 1'b0;
        n_checks++;
        if ({o_busy, o_done, o_err} !== 3'b000) begin
            n_fail++; $display("FAIL %s_ack_idle: busy/done/err=%b required 000", name, {o_busy, o_done, o_err});
        end
        if (go_ack) begin
            repeat (3) @(negedge clk);
            n_checks++;
            if ({o_busy, o_done, o_err} !== 3'b000) begin
                n_fail++; $display("FAIL %s_go_not_captured: busy/done/err=%b required 000", name, {o_busy, o_done, o_err});
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({xmsel_a, ymsel_a, xld_a, yld_a, gld_a, busy_a, done_a, err_a} !== 8'h00 || iters_a !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: outs=%b iters=%0d required all 0", {xmsel_a, ymsel_a, xld_a, yld_a, gld_a, busy_a, done_a, err_a}, iters_a);
        end
        do_reset();
        n_checks++;
        if ({busy_a, done_a, err_a, busy_b, done_b, err_b} !== 6'b0) begin
            n_fail++; $display("FAIL reset_release: status=%b required 000000", {busy_a, done_a, err_a, busy_b, done_b, err_b});
        end
    endtask

    task automatic test_basic();
        run_op(12, 8, 1'b0, 1'b0, 1'b0, "gcd_12_8");
        run_op(15, 1, 1'b0, 1'b0, 1'b0, "gcd_15_1");
        run_op(6, 10, 1'b0, 1'b0, 1'b0, "gcd_6_10");
        n_checks++;
        if (pair_seen !== 1'b0) begin
            n_fail++; $display("FAIL xld_yld_pair: both loads with a diff select seen=%0b required 0", pair_seen);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        run_op(15, 1, 1'b1, 1'b0, 1'b0, "timeout_15_1");
        do_reset();
    endtask

    task automatic test_zero_then_equal();
        run_op(9, 6, 1'b0, 1'b0, 1'b0, "pre_zero_9_6");
        run_op(0, 5, 1'b0, 1'b0, 1'b0, "zero_0_5");
        run_op(7, 7, 1'b0, 1'b0, 1'b0, "equal_7_7");
    endtask

    task automatic test_mid_reset();
        sel_b = 1'b0;
        xin = 4'd9; yin = 4'd6; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b1) begin
            n_fail++; $display("FAIL midrst_busy_before: got %0b required 1", busy_a);
        end
        clr = 1'b0;
        #1;
        n_checks++;
        if ({xld_a, yld_a, gld_a, busy_a, done_a, err_a} !== 6'b0 || iters_a !== 4'd0) begin
            n_fail++; $display("FAIL midrst_async: outs=%b iters=%0d required 0", {xld_a, yld_a, gld_a, busy_a, done_a, err_a}, iters_a);
        end
        @(negedge clk);
        clr = 1'b1;
        last_iters_a = 0; last_iters_b = 0;
        @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b0) begin
            n_fail++; $display("FAIL midrst_idle: busy=%0b required 0", busy_a);
        end
        run_op(9, 6, 1'b0, 1'b0, 1'b0, "after_rst_9_6");
    endtask

    task automatic test_back_to_back();
        run_op(12, 8, 1'b0, 1'b0, 1'b1, "go_ack_in_done");
        run_op(14, 4, 1'b0, 1'b1, 1'b0, "go_during_calc");
        run_op(5, 3, 1'b0, 1'b0, 1'b0, "back_to_back_5_3");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_zero_then_equal();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "bench time limit reached");
    end

endmodule

// File: doc/gcd_ctrl.md
Name: gcd_ctrl

Overview:
- Control FSM that sits directly upstream of the GCD datapath.
- Drives the datapath's mux selects and register load enables (xmsel, ymsel, xld, yld, gld) from its eqflg/ltflg feedback, running the subtractive Euclidean algorithm.
- Adds a go/done/ack handshake, zero-operand rejection, an iteration counter and a timeout error.
- A top level instantiates gcd_ctrl and the datapath side by side, sharing clk, clr, xin and yin.

Parameters:
- W, 4, operand width; must match the datapath xin/yin width.
- MAX_ITER, 15, maximum subtraction steps before timeout error. 15 covers the 4-bit worst case gcd(15,1) = 14 steps.
- CW, $clog2(MAX_ITER+1), iteration counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-low.
- go  in  1  start request; sampled only in IDLE.
- ack  in  1  result/error acknowledge; sampled only in DONE and ERR.
- xin  in  W  operand x; zero check only.
- yin  in  W  operand y; zero check only.
- eqflg  in  1  datapath x==y.
- ltflg  in  1  datapath x<y.
- xmsel  out  1  0 = load xin, 1 = load x−y.
- ymsel  out  1  0 = load yin, 1 = load y−x.
- xld  out  1  x register load enable.
- yld  out  1  y register load enable.
- gld  out  1  gcd register load enable.
- busy  out  1  high in LOAD and CALC.
- done  out  1  high in DONE.
- err  out  1  high in ERR.
- iters  out  CW  subtraction steps taken in the current/last run.

Behaviour:
- Reset (clr=0, async): state=IDLE, iters=0, all outputs 0.
- Release of reset is synchronous to clk.
- States: IDLE, LOAD, CALC, GLD, DONE, ERR.
- State and iters are registered. Outputs are decoded combinationally from state, plus eqflg/ltflg in CALC (Mealy).
- Any output not listed for a state is 0.
- IDLE:
  - go=1 with xin==0 or yin==0 -> ERR.
  - go=1 otherwise -> LOAD; iters cleared to 0.
  - go=0 -> stay.
- LOAD: xmsel=0, ymsel=0, xld=1, yld=1, busy=1; -> CALC.
- CALC (busy=1), checked in priority order:
  - eqflg=1 -> no loads; -> GLD.
  - else if iters==MAX_ITER -> no loads; -> ERR (timeout).
  - else if ltflg=1 -> ymsel=1, yld=1, iters+1; stay.
  - else -> xmsel=1, xld=1, iters+1; stay.
- GLD: gld=1; -> DONE.
- DONE: done=1; gcd output valid from this cycle. ack=1 -> IDLE, otherwise hold.
- ERR: err=1; ack=1 -> IDLE, otherwise hold.
- iters holds its value in GLD/DONE/ERR/IDLE and clears only on an accepted go.
- Latency: accepted go at edge N → LOAD N+1 → CALC N+2 … → DONE at N + 4 + steps.
- go in LOAD/CALC/GLD/DONE/ERR: ignored, not queued.
- ack outside DONE/ERR: ignored.
- go and ack both high in DONE: ack wins -> IDLE; go is not captured and must be held or re-asserted.
- Reset mid-run: immediate return to IDLE; datapath registers are cleared by the same clr.
- Never assert xld and yld together except in LOAD.
- Never assert gld outside GLD.
- Illegal state encodings recover to IDLE on the next edge.

Decomposition:
- Package gcd_pkg holds:
  - state enum (IDLE, LOAD, CALC, GLD, DONE, ERR);
  - GCD_W = 4;
  - GCD_MAX_ITER = 15;
  - mux select constants SEL_IN = 0, SEL_DIFF = 1.
- No sub-module needed; the iteration counter is inline.
- gcd_top wires gcd_ctrl to the datapath; it is a separate, trivial file.

Test Plan:
- xin=12, yin=8, pulse go -> LOAD, then CALC issues xld (x=4), then yld (y=4), then GLD; done=1 on cycle 6 after go; gcd=4, iters=2; ack -> IDLE.
- xin=15, yin=1 -> 14 xld steps; done; gcd=1, iters=14, err=0.
- MAX_ITER=3, xin=15, yin=1 -> after 3 steps CALC goes to ERR; err=1, iters=3, gld never asserted; ack -> IDLE.
- xin=0, yin=5, go -> ERR next cycle with no loads issued. Then xin=7, yin=7, ack then go -> CALC sees eqflg immediately; gcd=7, iters=0.
- Mid-run (xin=9, yin=6 in CALC), drive clr=0 -> outputs 0 asynchronously; after release, state IDLE, go restarts cleanly and gives gcd=3.
- In DONE, go=1 and ack=1 together -> IDLE, no new run. go asserted during CALC -> ignored, result unchanged.
